// File: rtl/fetch_unit.sv
// Program counter / instruction register stage with jump-to-self halt detection and a retired-cycle counter.
// Optional hardware single-stepping is enabled by defining FETCH_SINGLE_STEP_EN.
module fetch_unit #(
   parameter int CYCLE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         bus,
   input  logic               loadBarIR,
   input  logic               doJumpBar,
`ifdef FETCH_SINGLE_STEP_EN
   input  logic               stepMode,
   input  logic               stepReq,
`endif
   output logic [7:0]         pc,
   output logic [7:0]         ir,
   output logic [7:0]         instrPc,
   output logic               halted,
   output logic [CYCLE_W-1:0] cycles
);

   // state | meaning
   // RUN   | free-running, every cycle advances
   // HALT  | jump-to-self seen, frozen until reset
   // WAIT  | single-step mode, advance only on a stepReq rising edge
   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] HALT = 2'd1;
`ifdef FETCH_SINGLE_STEP_EN
   localparam logic [1:0] WAIT = 2'd2;
`endif

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       advance;
   logic       self_jump;

`ifdef FETCH_SINGLE_STEP_EN
   logic step_sync1;
   logic step_sync2;
   logic step_prev;
   logic step_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_sync1 <= 1'b0;
         step_sync2 <= 1'b0;
         step_prev  <= 1'b0;
      end else begin
         step_sync1 <= stepReq;
         step_sync2 <= step_sync1;
         step_prev  <= step_sync2;
      end
   end

   assign step_grant = (state == WAIT) && step_sync2 && !step_prev;
   assign advance    = (state == RUN) || step_grant;
`else
   assign advance    = (state == RUN);
`endif

   assign self_jump = advance && !doJumpBar && (bus == instrPc);

   always_comb begin
      state_nxt = state;
      if (state != HALT) begin
         if (self_jump) begin
            state_nxt = HALT;
`ifdef FETCH_SINGLE_STEP_EN
         end else if (state == RUN && stepMode) begin
            state_nxt = WAIT;
         end else if (state == WAIT && !stepMode) begin
            state_nxt = RUN;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         pc      <= 8'h00;
         ir      <= 8'h00;
         instrPc <= 8'h00;
         cycles  <= '0;
      end else begin
         state <= state_nxt;
         if (advance) begin
            pc     <= doJumpBar ? pc + 8'd1 : bus;
            cycles <= cycles + CYCLE_W'(1);
            // instrPc takes the pre-jump pc even when both strobes are low
            if (!loadBarIR) begin
               ir      <= bus;
               instrPc <= pc;
            end
         end
      end
   end

   assign halted = (state == HALT);

endmodule
